// File: rtl/fm_demodulator.sv
// fm_demodulator
//   Gated zero-crossing FM demodulator. Counts rising zero crossings of the
//   registered sample stream over a 2^GATE_LOG2-clock gate window. It then
//   turns the count into a frequency-control estimate, removes the center
//   control word, undoes the modulator's deviation shift and saturates the
//   result to a signed 8-bit message.
//
//   Ports
//     clk        sample clock, rising edge
//     reset_n    asynchronous active-low reset
//     modulated  signed 8-bit FM sample, one per clock
//     ctr_ctrl   center-frequency control word (NCO scaling)
//     deviation  left-shift the modulator applied to the message
//     message    recovered signed message, held between updates
//     valid      one-cycle pulse when message updates
//     saturated  result was clipped; updated together with message
module fm_demodulator #(
  parameter int GATE_LOG2 = 16,
  parameter int HYST      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic signed [7:0] modulated,
  input  logic [31:0]       ctr_ctrl,
  input  logic [4:0]        deviation,
  output logic signed [7:0] message,
  output logic              valid,
  output logic              saturated
);

  localparam int CW        = GATE_LOG2 + 1;
  localparam int EST_SHIFT = 32 - GATE_LOG2;
  localparam int ARM_LVL   = -HYST;

  typedef enum logic {DISARMED = 1'b0, ARMED = 1'b1} det_e;

  logic signed [7:0]    s_q;
  det_e                 det_q, det_d;
  logic                 xing;
  logic [GATE_LOG2-1:0] gate_q;
  logic                 terminal;
  logic [CW-1:0]        cnt_q, cnt_inc, cnt_d;
  logic [CW-1:0]        tot_q;
  logic [33:0]          ctrl_est, diff_d, diff_q;
  logic [4:0]           dev_q;
  logic signed [33:0]   q_sh;
  logic signed [7:0]    msg_d, msg_q;
  logic                 sat_d, sat_q;
  // [0] total captured, [1] diff captured, [2] message captured
  logic [2:0]           vld_pipe_q;

  // Crossing detector: a sample at or below -HYST arms, the next
  // non-negative sample is the crossing and disarms.
  always_comb begin
    det_d = det_q;
    xing  = 1'b0;
    case (det_q)
      DISARMED: if (int'(s_q) <= ARM_LVL) det_d = ARMED;
      ARMED: begin
        if (s_q >= 8'sd0) begin
          det_d = DISARMED;
          xing  = 1'b1;
        end
      end
      default: det_d = DISARMED;
    endcase
  end

  assign terminal = &gate_q;

  // Saturating count; the terminal-cycle crossing still lands in the
  // ending window's total, and the counter restarts from zero.
  always_comb begin
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(xing);
    cnt_d   = terminal ? '0 : cnt_inc;
  end

  // Stage 1: one crossing per window is worth 2^(32-GATE_LOG2) control LSBs.
  assign ctrl_est = 34'(tot_q) << EST_SHIFT;
  assign diff_d   = ctrl_est - {2'b00, ctr_ctrl};

  // Stage 2: arithmetic shift floors toward -inf, then clip to int8.
  assign q_sh = $signed(diff_q) >>> dev_q;

  always_comb begin
    msg_d = q_sh[7:0];
    sat_d = 1'b0;
    if (q_sh > 34'sd127) begin
      msg_d = 8'sd127;
      sat_d = 1'b1;
    end else if (q_sh < -34'sd128) begin
      msg_d = -8'sd128;
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q        <= '0;
      det_q      <= DISARMED;
      gate_q     <= '0;
      cnt_q      <= '0;
      tot_q      <= '0;
      diff_q     <= '0;
      dev_q      <= '0;
      msg_q      <= '0;
      sat_q      <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      s_q        <= modulated;
      det_q      <= det_d;
      gate_q     <= gate_q + GATE_LOG2'(1);
      cnt_q      <= cnt_d;
      vld_pipe_q <= {vld_pipe_q[1:0], terminal};
      if (terminal) tot_q <= cnt_inc;
      if (vld_pipe_q[0]) begin
        diff_q <= diff_d;
        dev_q  <= deviation;
      end
      if (vld_pipe_q[1]) begin
        msg_q <= msg_d;
        sat_q <= sat_d;
      end
    end
  end

  assign message   = msg_q;
  assign saturated = sat_q;
  assign valid     = vld_pipe_q[2];

endmodule

// File: tb/tb_fm_demodulator.sv
// Testbench for fm_demodulator (GATE_LOG2=8, HYST=8). A square-wave NCO
// with random amplitudes, fixed patterns and random noise drive the input.
// A window-level reference model counts crossings from the driven sample
// history and predicts every update. Scenario constants are checked as well.
module tb_fm_demodulator;
  localparam int GL  = 8;
  localparam int HY  = 8;
  localparam int WIN = 1 << GL;
  localparam int M_NCO = 0, M_PAT = 1, M_NOISE = 2, M_ZERO = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic signed [7:0] modulated;
  logic [31:0]       ctr_ctrl;
  logic [4:0]        deviation;
  logic signed [7:0] message;
  logic              valid;
  logic              saturated;

  fm_demodulator #(.GATE_LOG2(GL), .HYST(HY)) dut (
    .clk(clk), .reset_n(reset_n), .modulated(modulated), .ctr_ctrl(ctr_ctrl),
    .deviation(deviation), .message(message), .valid(valid), .saturated(saturated)
  );

  always #5 clk = ~clk;

  // stimulus state
  int          mode;
  logic [31:0] phase, nco_ctrl;
  int          pat, lo_lvl, hi_lvl;
  bit          rnd_ctl;
  // reference model state
  int cyc, edge_n, prev_s, wcnt, tot_val, tot_edge, res_edge, res_msg, held_msg;
  bit last_low, tot_pend, res_pend, res_sat, exp_v, held_sat;
  // scoring
  int checks = 0, errors = 0;
  int first_v, prev_v, ts;

  function automatic longint floor_div_pow2(longint d, int sh);
    longint p;
    p = longint'(1) << sh;
    if (d >= 0) return d / p;
    return -((-d + p - 1) / p);
  endfunction

  task automatic model_reset();
    cyc = 0; prev_s = 0; last_low = 0; wcnt = 0;
    tot_pend = 0; res_pend = 0; exp_v = 0; held_msg = 0; held_sat = 0;
    phase = 32'h8000_0000; pat = 0;
  endtask

  // Drive one sample, take one clock edge, and advance the model to match.
  task automatic step();
    int v;
    longint est, diff, q;
    if (rnd_ctl && $urandom_range(7, 0) == 0) begin
      ctr_ctrl  = (32'($urandom_range(90, 40)) << 24) | ($urandom & 32'h00FF_FFFF);
      deviation = 5'($urandom_range(31, 18));
    end
    case (mode)
      M_NCO: begin
        phase = phase + nco_ctrl;
        v = phase[31] ? -int'($urandom_range(128, 8)) : int'($urandom_range(127, 0));
      end
      M_PAT: begin
        v = ((pat / 4) % 2 == 0) ? lo_lvl : hi_lvl;
        pat++;
      end
      M_NOISE: v = int'($urandom_range(255, 0)) - 128;
      default: v = 0;
    endcase
    modulated = 8'(v);
    @(posedge clk);
    #1;
    edge_n = cyc;
    // result emerges two edges after the window's stage-1 edge
    exp_v = 0;
    if (res_pend && cyc == res_edge) begin
      exp_v = 1; held_msg = res_msg; held_sat = res_sat; res_pend = 0;
    end
    // stage 1 takes ctr_ctrl/deviation present at the edge after the terminal
    if (tot_pend && cyc == tot_edge + 1) begin
      est  = longint'(tot_val) << (32 - GL);
      diff = est - longint'(ctr_ctrl);
      q    = floor_div_pow2(diff, int'(deviation));
      if (q > 127)       begin res_msg = 127;    res_sat = 1; end
      else if (q < -128) begin res_msg = -128;   res_sat = 1; end
      else               begin res_msg = int'(q); res_sat = 0; end
      res_pend = 1; res_edge = cyc + 1; tot_pend = 0;
    end
    // crossing: non-negative sample whose last decisive sample was low
    if (prev_s >= 0 && last_low) wcnt++;
    if (prev_s <= -HY) last_low = 1;
    else if (prev_s >= 0) last_low = 0;
    if (cyc % WIN == WIN - 1) begin
      tot_val = (wcnt > 2 * WIN - 1) ? 2 * WIN - 1 : wcnt;
      wcnt = 0; tot_pend = 1; tot_edge = cyc;
    end
    prev_s = int'($signed(8'(v)));
    cyc++;
  endtask

  task automatic test_reset();
    checks++;
    if (valid !== 1'b0 || message !== 8'sd0 || saturated !== 1'b0) begin
      errors++; $display("FAIL reset_state got v=%b m=%0d s=%b exp 0/0/0", valid, message, saturated);
    end
    modulated = -8'sd100;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0 || message !== 8'sd0 || saturated !== 1'b0) begin
      errors++; $display("FAIL reset_hold got v=%b m=%0d s=%b exp 0/0/0", valid, message, saturated);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_center();
    mode = M_NCO; nco_ctrl = 32'h1000_0000; ctr_ctrl = 32'h1000_0000; deviation = 5'd20;
    first_v = -1; prev_v = -1;
    for (int i = 0; i < 4 * WIN - 1; i++) begin
      step();
      checks++;
      if (valid !== exp_v) begin
        errors++; $display("FAIL center_valid edge=%0d got=%b exp=%b", edge_n, valid, exp_v);
      end
      checks++;
      if (message !== 8'(held_msg) || saturated !== held_sat) begin
        errors++; $display("FAIL center_model edge=%0d got=%0d/%b exp=%0d/%b", edge_n, message, saturated, held_msg, held_sat);
      end
      if (valid === 1'b1) begin
        checks++;
        if (first_v < 0) begin
          if (edge_n != WIN + 1) begin
            errors++; $display("FAIL center_first_valid got=%0d exp=%0d", edge_n, WIN + 1);
          end
        end else if (edge_n - prev_v != WIN) begin
          errors++; $display("FAIL center_spacing got=%0d exp=%0d", edge_n - prev_v, WIN);
        end
        if (first_v < 0) first_v = edge_n;
        prev_v = edge_n;
        checks++;
        if (message !== 8'sd0 || saturated !== 1'b0) begin
          errors++; $display("FAIL center_value edge=%0d got=%0d/%b exp=0/0", edge_n, message, saturated);
        end
      end
    end
    checks++;
    if (first_v < 0) begin
      errors++; $display("FAIL center_no_valid got=none exp=edge %0d", WIN + 1);
    end
  endtask

  task automatic test_deviation();
    int m;
    for (int p = 0; p < 4; p++) begin
      m = (p == 0) ? 16 : (p == 1) ? -16 : int'($urandom_range(200, 0)) - 100;
      nco_ctrl = 32'h1000_0000 + 32'(m * (1 << 20));
      ts = cyc;
      for (int i = 0; i < 2 * WIN; i++) begin
        step();
        checks++;
        if (valid !== exp_v) begin
          errors++; $display("FAIL dev_valid edge=%0d got=%b exp=%b", edge_n, valid, exp_v);
        end
        checks++;
        if (message !== 8'(held_msg) || saturated !== held_sat) begin
          errors++; $display("FAIL dev_model m=%0d edge=%0d got=%0d/%b exp=%0d/%b", m, edge_n, message, saturated, held_msg, held_sat);
        end
        if (p < 2 && valid === 1'b1 && edge_n >= ts + WIN + 2) begin
          checks++;
          if (message !== 8'(m) || saturated !== 1'b0) begin
            errors++; $display("FAIL dev_value edge=%0d got=%0d/%b exp=%0d/0", edge_n, message, saturated, m);
          end
        end
      end
    end
  endtask

  task automatic test_saturation();
    nco_ctrl = 32'h1000_0000;
    for (int p = 0; p < 2; p++) begin
      ctr_ctrl  = (p == 0) ? 32'h0F00_0000 : 32'h1000_0000;
      deviation = 5'd16;
      ts = cyc;
      for (int i = 0; i < 2 * WIN; i++) begin
        step();
        checks++;
        if (valid !== exp_v) begin
          errors++; $display("FAIL sat_valid edge=%0d got=%b exp=%b", edge_n, valid, exp_v);
        end
        checks++;
        if (message !== 8'(held_msg) || saturated !== held_sat) begin
          errors++; $display("FAIL sat_model edge=%0d got=%0d/%b exp=%0d/%b", edge_n, message, saturated, held_msg, held_sat);
        end
        if (valid === 1'b1 && (p == 1 || edge_n >= ts + WIN + 2)) begin
          checks++;
          if (p == 0 && (message !== 8'sd127 || saturated !== 1'b1)) begin
            errors++; $display("FAIL sat_clip edge=%0d got=%0d/%b exp=127/1", edge_n, message, saturated);
          end else if (p == 1 && (message !== 8'sd0 || saturated !== 1'b0)) begin
            errors++; $display("FAIL sat_clear edge=%0d got=%0d/%b exp=0/0", edge_n, message, saturated);
          end
        end
      end
    end
  endtask

  task automatic test_hysteresis();
    mode = M_PAT; ctr_ctrl = 32'h0; deviation = 5'd0; hi_lvl = 4;
    for (int p = 0; p < 2; p++) begin
      lo_lvl = (p == 0) ? -4 : -9;
      pat = 0;
      ts = cyc;
      for (int i = 0; i < (p == 0 ? 3 : 2) * WIN; i++) begin
        step();
        checks++;
        if (valid !== exp_v) begin
          errors++; $display("FAIL hyst_valid edge=%0d got=%b exp=%b", edge_n, valid, exp_v);
        end
        checks++;
        if (message !== 8'(held_msg) || saturated !== held_sat) begin
          errors++; $display("FAIL hyst_model edge=%0d got=%0d/%b exp=%0d/%b", edge_n, message, saturated, held_msg, held_sat);
        end
        if (valid === 1'b1 && edge_n >= ts + (p == 0 ? 2 * WIN : WIN) + 2) begin
          checks++;
          if (p == 0 && (message !== 8'sd0 || saturated !== 1'b0)) begin
            errors++; $display("FAIL hyst_none edge=%0d got=%0d/%b exp=0/0", edge_n, message, saturated);
          end else if (p == 1 && (message !== 8'sd127 || saturated !== 1'b1)) begin
            errors++; $display("FAIL hyst_armed edge=%0d got=%0d/%b exp=127/1", edge_n, message, saturated);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    mode = M_NCO; nco_ctrl = 32'h1000_0000; ctr_ctrl = 32'h1000_0000; deviation = 5'd20;
    for (int i = 0; i < WIN; i++) begin
      if (cyc % WIN == 100) break;
      step();
      checks++;
      if (valid !== exp_v || message !== 8'(held_msg) || saturated !== held_sat) begin
        errors++; $display("FAIL rmid_pre edge=%0d got=%b/%0d/%b exp=%b/%0d/%b", edge_n, valid, message, saturated, exp_v, held_msg, held_sat);
      end
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || message !== 8'sd0 || saturated !== 1'b0) begin
      errors++; $display("FAIL rmid_clear got v=%b m=%0d s=%b exp 0/0/0", valid, message, saturated);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0 || message !== 8'sd0) begin
      errors++; $display("FAIL rmid_hold got v=%b m=%0d exp 0/0", valid, message);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    first_v = -1;
    for (int i = 0; i < 4 * WIN - 1; i++) begin
      step();
      checks++;
      if (valid !== exp_v) begin
        errors++; $display("FAIL rmid_valid edge=%0d got=%b exp=%b", edge_n, valid, exp_v);
      end
      checks++;
      if (message !== 8'(held_msg) || saturated !== held_sat) begin
        errors++; $display("FAIL rmid_model edge=%0d got=%0d/%b exp=%0d/%b", edge_n, message, saturated, held_msg, held_sat);
      end
      if (valid === 1'b1 && first_v < 0) begin
        first_v = edge_n;
        checks++;
        if (edge_n != WIN + 1 || message !== 8'sd0 || saturated !== 1'b0) begin
          errors++; $display("FAIL rmid_first edge=%0d got=%0d/%b exp edge=%0d 0/0", edge_n, message, saturated, WIN + 1);
        end
      end
    end
  endtask

  task automatic test_noise();
    mode = M_NOISE; rnd_ctl = 1'b1;
    for (int i = 0; i < 4 * WIN; i++) begin
      step();
      checks++;
      if (valid !== exp_v) begin
        errors++; $display("FAIL noise_valid edge=%0d got=%b exp=%b", edge_n, valid, exp_v);
      end
      checks++;
      if (message !== 8'(held_msg) || saturated !== held_sat) begin
        errors++; $display("FAIL noise_model edge=%0d got=%0d/%b exp=%0d/%b", edge_n, message, saturated, held_msg, held_sat);
      end
    end
    rnd_ctl = 1'b0;
  endtask

  // Constant zero input: no crossings, diff = -ctr_ctrl; -257 >>> 4 floors to -17.
  task automatic test_zero();
    mode = M_ZERO; ctr_ctrl = 32'h0000_0101; deviation = 5'd4;
    ts = cyc;
    for (int i = 0; i < 3 * WIN; i++) begin
      step();
      checks++;
      if (valid !== exp_v || message !== 8'(held_msg) || saturated !== held_sat) begin
        errors++; $display("FAIL zero_model edge=%0d got=%b/%0d/%b exp=%b/%0d/%b", edge_n, valid, message, saturated, exp_v, held_msg, held_sat);
      end
      if (valid === 1'b1 && edge_n >= ts + 2 * WIN + 2) begin
        checks++;
        if (message !== -8'sd17 || saturated !== 1'b0) begin
          errors++; $display("FAIL zero_floor edge=%0d got=%0d/%b exp=-17/0", edge_n, message, saturated);
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; modulated = '0; ctr_ctrl = '0; deviation = '0;
    mode = M_ZERO; nco_ctrl = '0; rnd_ctl = 1'b0; lo_lvl = 0; hi_lvl = 0;
    model_reset();
    #1;
    test_reset();
    test_center();
    test_deviation();
    test_saturation();
    test_hysteresis();
    test_reset_mid();
    test_noise();
    test_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fm_demodulator.md
# fm_demodulator

Gated zero-crossing FM demodulator: recovers the signed 8-bit message from a signed 8-bit FM sample stream produced by the FM modulator/NCO path. It uses the same center-frequency control word and deviation shift as the transmit side. Each gate window counts rising zero crossings and converts the count to a frequency-control estimate. It then subtracts the center control word, undoes the deviation shift, and saturates the result. The block sits on the receive/loopback side of the waveform generator, one sample per clock.

## Interface
- GATE_LOG2, 16: gate window length is 2^GATE_LOG2 clocks; legal range 4..24.
- HYST, 8: arming threshold; a sample <= -HYST arms crossing detection; legal range 0..127.
- clk  input  1  sample clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- modulated  input  8  signed FM sample, one per clock.
- ctr_ctrl  input  32  center-frequency control word, same scaling as the modulator NCO.
- deviation  input  5  left-shift amount the modulator applied to the message.
- message  output  8  signed recovered message, held between updates.
- valid  output  1  one-cycle pulse when `message` updates.
- saturated  output  1  set with each update if the result was clipped; held until the next update.

## Operation
- **Input register:**
  - `modulated` is registered into s_reg.
  - All detection uses s_reg, so input-to-detection latency is 1 cycle.
- **Crossing detector.** Two states, DISARMED and ARMED.
  - DISARMED -> ARMED when s_reg <= -HYST (signed compare).
  - ARMED -> DISARMED when s_reg >= 0. That cycle is a crossing event.
  - The arm and crossing conditions are mutually exclusive for any single sample.
  - The state resets to DISARMED.
- **Gate counter:**
  - Free-running GATE_LOG2-bit counter, reset to 0.
  - The terminal cycle is the one where the counter is all ones; the counter then wraps to 0.
- **Crossing counter:**
  - Width GATE_LOG2+1 bits, saturating at all ones and never wrapping.
  - Increments on each crossing event outside the terminal cycle.
  - In the terminal cycle: total = count + (crossing event this cycle ? 1 : 0), saturating. The count is cleared to 0 in the same cycle.
  - A crossing in the terminal cycle belongs to the ending window. A crossing in the next cycle belongs to the new window.
- **Pipeline stage 1** (cycle after terminal):
  - ctrl_est = total << (32 - GATE_LOG2), formed in 34-bit unsigned.
  - diff = ctrl_est - {2'b00, ctr_ctrl}, 34-bit two's complement.
  - `ctr_ctrl` and `deviation` are sampled in this cycle; `deviation` is registered alongside diff.
- **Pipeline stage 2:**
  - q = diff >>> deviation (arithmetic shift, truncating toward negative infinity).
  - If q > 127: message = 127, saturated = 1.
  - If q < -128: message = -128, saturated = 1.
  - Otherwise message = q[7:0], saturated = 0.
  - valid pulses for exactly one cycle.
- **Resolution:** one crossing per window equals 2^(32-GATE_LOG2) control LSBs, i.e. 2^(32-GATE_LOG2-deviation) message LSBs.
- `ctr_ctrl` and `deviation` may change at any time. Only their values at stage 1 affect an update.

## Timing
- **Reset values:**
  - message = 0, valid = 0, saturated = 0.
  - s_reg = 0, gate counter = 0, crossing count = 0, detector DISARMED, pipeline registers = 0.
- **Latency:** valid rises 2 cycles after the terminal cycle.
  - The first valid after reset release occurs at cycle 2^GATE_LOG2 + 1, counting the first active edge as cycle 0.
  - Subsequent valid pulses are exactly 2^GATE_LOG2 cycles apart.
- `message` and `saturated` change only on the valid cycle.
- **Reset mid-operation** (asynchronous assertion at any point):
  - Clears all state immediately, including any in-flight pipeline result.
  - No valid is issued for the partial window.
  - Timing restarts from the release as after power-up.
- **Zero or constant input:** produces no crossings, so total = 0 and diff = -ctr_ctrl. The result saturates negative unless ctr_ctrl is small.
- **Crossing count saturation:** affects only the estimate; the block continues operating normally.

## Test plan
All scenarios use GATE_LOG2 = 8, HYST = 8, and the modulator/NCO output looped into `modulated`.
- **Center, no message.** ctr_ctrl = 0x1000_0000, message 0, deviation 20.
  - 16 crossings per window; every update gives message = 0, saturated = 0.
  - valid pulses spaced exactly 256 cycles apart; first at cycle 257.
- **Positive deviation.** Modulator message +16, deviation 20 (control 0x1100_0000).
  - 17 crossings per window; recovered message = +16.
- **Negative deviation.** Modulator message -16 (control 0x0F00_0000).
  - 15 crossings per window; recovered message = -16.
- **Saturation.** Input at 16 crossings/window, ctr_ctrl = 0x0F00_0000, deviation 16.
  - diff = 0x0100_0000, shifted value = 256, so message = 127, saturated = 1.
  - Next window with ctr_ctrl = 0x1000_0000: message = 0, saturated = 0.
- **Hysteresis.** Square input alternating -4/+4 every 4 cycles, ctr_ctrl = 0, deviation 0.
  - 0 crossings; message = 0.
  - The same pattern at -9/+4 gives 32 crossings: diff = 32 << 24, so message = 127, saturated = 1.
- **Reset mid-window.** Assert reset_n low at cycle 100 for 3 cycles.
  - message = 0, valid = 0 immediately; no valid before 257 cycles after release.
  - The next result matches the undisturbed value.
